// File: rtl/fp_divsqrt_sched.sv
// fp_divsqrt_sched: issue/writeback scheduler for the shared iterative
// fdiv/fsqrt unit. It accepts one op from ID, pulses the unit's start and
// counts down the op's latency. It then writes the result through the FPR
// second write port whenever the e3 writer leaves that port free. It also
// stalls ID/IF for structural hazards and for RAW/WAW hazards on the
// destination register of the op in flight.
// Optional feature macro: FP_DIVSQRT_PERF_EN adds the stall_cycles and
// wb_defer_cycles performance counters.
module fp_divsqrt_sched #(
  parameter int DIV_LAT  = 20,
  parameter int SQRT_LAT = 24,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          issue_valid,
  input  logic          issue_op,
  input  logic [4:0]    issue_fd,
  input  logic          pipe_stall_in,
  input  logic [4:0]    id_fs,
  input  logic [4:0]    id_ft,
  input  logic          id_use_fs,
  input  logic          id_use_ft,
  input  logic          id_wf,
  input  logic [4:0]    id_fd,
  input  logic          wb_port_free,
  output logic          start,
  output logic          start_op,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          stall_ds,
  output logic          wb_we,
  output logic [4:0]    wb_rn,
`ifdef FP_DIVSQRT_PERF_EN
  output logic          wb_op,
  output logic [31:0]   stall_cycles,
  output logic [15:0]   wb_defer_cycles
`else
  output logic          wb_op
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_WB = 2'd2
  } state_t;

  // Count is loaded with LAT-1 so that the result lands LAT cycles after start.
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);
  localparam logic [CW-1:0] SQRT_LOAD = CW'(SQRT_LAT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [4:0]    fd_reg, fd_next;
  logic          op_reg, op_next;

  logic wb_fire;
  logic free_now;
  logic src_match;
  logic haz;
  logic accept;

  // State, countdown and latched destination/op registers.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_reg <= IDLE;
      count_reg <= '0;
      fd_reg    <= '0;
      op_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      fd_reg    <= fd_next;
      op_reg    <= op_next;
    end
  end

  // Writeback, hazard and accept decisions; next-state and countdown logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    fd_next    = fd_reg;
    op_next    = op_reg;

    // The e3 writer always wins the port; the result only fires when the port is free.
    wb_fire = wb_port_free &
              (((state_reg == RUN) && (count_reg == '0)) || (state_reg == WAIT_WB));

    // The unit can take a new op if it is idle or if its result drains this cycle.
    free_now = (state_reg == IDLE) | wb_fire;

    src_match = (id_use_fs && (id_fs == fd_reg)) ||
                (id_use_ft && (id_ft == fd_reg)) ||
                (id_wf     && (id_fd == fd_reg));

    // The FPR write completes on the falling edge, so the hazard drops in the write cycle.
    haz = (state_reg != IDLE) & ~wb_fire & src_match;

    accept = issue_valid & ~pipe_stall_in & free_now & ~haz;

    unique case (state_reg)
      IDLE: begin
        count_next = '0;
      end
      RUN: begin
        if (count_reg != '0) begin
          count_next = count_reg - 1'b1;
        end else if (wb_fire) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_WB;
        end
      end
      WAIT_WB: begin
        count_next = '0;
        if (wb_fire) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase

    // A new accept overrides the drain to IDLE (back-to-back issue).
    if (accept) begin
      state_next = RUN;
      count_next = issue_op ? SQRT_LOAD : DIV_LOAD;
      fd_next    = issue_fd;
      op_next    = issue_op;
    end
  end

  // Output drive; write-port fields are zero when not writing.
  always_comb begin
    start    = accept;
    start_op = accept & issue_op;
    busy     = (state_reg != IDLE);
    count    = count_reg;
    stall_ds = haz | (issue_valid & ~free_now);
    wb_we    = wb_fire;
    wb_rn    = wb_fire ? fd_reg : 5'd0;
    wb_op    = wb_fire & op_reg;
  end

`ifdef FP_DIVSQRT_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] wb_defer_cycles_reg;

  // Saturating counters of stall cycles and of cycles spent waiting for the port.
  always_ff @(posedge clk) begin
    if (clrn) begin
      stall_cycles_reg    <= '0;
      wb_defer_cycles_reg <= '0;
    end else begin
      if (stall_ds && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if ((state_reg == WAIT_WB) && (wb_defer_cycles_reg != 16'hFFFF)) begin
        wb_defer_cycles_reg <= wb_defer_cycles_reg + 16'd1;
      end
    end
  end

  assign stall_cycles    = stall_cycles_reg;
  assign wb_defer_cycles = wb_defer_cycles_reg;
`endif

endmodule

// File: tb/tb_fp_divsqrt_sched.sv
// tb_fp_divsqrt_sched: directed scenarios followed by randomized traffic.
// Every cycle is checked against a timeline model: the model keeps the
// absolute cycle at which the in-flight result becomes ready and derives
// the expected outputs from that cycle.
module tb_fp_divsqrt_sched;

  localparam int DIV_LAT  = 20;
  localparam int SQRT_LAT = 24;
  localparam int CW       = 5;

  logic          clk = 1'b0;
  logic          clrn;
  logic          issue_valid, issue_op;
  logic [4:0]    issue_fd;
  logic          pipe_stall_in;
  logic [4:0]    id_fs, id_ft, id_fd;
  logic          id_use_fs, id_use_ft, id_wf;
  logic          wb_port_free;
  logic          start, start_op, busy, stall_ds, wb_we, wb_op;
  logic [CW-1:0] count;
  logic [4:0]    wb_rn;
`ifdef FP_DIVSQRT_PERF_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   wb_defer_cycles;
`endif

  int vectors   = 0;
  int miscompares = 0;

  // Model state: pending op, absolute ready cycle, destination, op.
  bit m_pend = 1'b0;
  int m_ready = 0;
  int m_fd = 0;
  bit m_op = 1'b0;
  int cyc = 0;

  always #5 clk = ~clk;

  fp_divsqrt_sched #(.DIV_LAT(DIV_LAT), .SQRT_LAT(SQRT_LAT), .CW(CW)) dut (
    .clk(clk), .clrn(clrn),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_fd(issue_fd),
    .pipe_stall_in(pipe_stall_in),
    .id_fs(id_fs), .id_ft(id_ft), .id_use_fs(id_use_fs), .id_use_ft(id_use_ft),
    .id_wf(id_wf), .id_fd(id_fd), .wb_port_free(wb_port_free),
    .start(start), .start_op(start_op), .busy(busy), .count(count),
    .stall_ds(stall_ds), .wb_we(wb_we), .wb_rn(wb_rn),
`ifdef FP_DIVSQRT_PERF_EN
    .wb_op(wb_op), .stall_cycles(stall_cycles), .wb_defer_cycles(wb_defer_cycles)
`else
    .wb_op(wb_op)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    clrn = 1'b0; issue_valid = 1'b0; issue_op = 1'b0; issue_fd = 5'd0;
    pipe_stall_in = 1'b0; id_fs = 5'd0; id_ft = 5'd0; id_fd = 5'd0;
    id_use_fs = 1'b0; id_use_ft = 1'b0; id_wf = 1'b0; wb_port_free = 1'b1;
  endtask

  // Apply the current inputs for one cycle: check outputs, then advance the model.
  task automatic step();
    bit ready, wbf, free, match, haz, acc, stall;
    int exp_cnt;
    #1;
    ready = m_pend && (cyc >= m_ready);
    wbf   = ready && wb_port_free;
    free  = !m_pend || wbf;
    match = (id_use_fs && (int'(id_fs) == m_fd)) ||
            (id_use_ft && (int'(id_ft) == m_fd)) ||
            (id_wf && (int'(id_fd) == m_fd));
    haz   = m_pend && !wbf && match;
    acc   = issue_valid && !pipe_stall_in && free && !haz;
    stall = haz || (issue_valid && !free);
    exp_cnt = (m_pend && (m_ready > cyc)) ? (m_ready - cyc) : 0;

    check("start",    32'(start),    32'(acc));
    check("start_op", 32'(start_op), 32'(acc && issue_op));
    check("busy",     32'(busy),     32'(m_pend));
    check("count",    32'(count),    32'(exp_cnt));
    check("stall_ds", 32'(stall_ds), 32'(stall));
    check("wb_we",    32'(wb_we),    32'(wbf));
    if (wbf) begin
      check("wb_rn", 32'(wb_rn), 32'(m_fd));
      check("wb_op", 32'(wb_op), 32'(m_op));
    end

    @(posedge clk);
    if (clrn) begin
      m_pend = 1'b0; m_fd = 0; m_op = 1'b0;
    end else if (acc) begin
      m_pend  = 1'b1;
      m_ready = cyc + 1 + (issue_op ? SQRT_LAT : DIV_LAT) - 1;
      m_fd    = int'(issue_fd);
      m_op    = issue_op;
    end else if (wbf) begin
      m_pend = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    idle_inputs();
    clrn = 1'b1;
    for (int i = 0; i < n; i++) step();
    clrn = 1'b0;
  endtask

  task automatic run_idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    idle_inputs();
    clrn = 1'b1;
    @(negedge clk);
    do_reset(2);
    run_idle(2);

    // fdiv fd=3, then fsqrt fd=4 held from cycle 5 until it gets in (cycle 20).
    for (int i = 0; i < 50; i++) begin
      idle_inputs();
      if (i == 0) begin
        issue_valid = 1'b1; issue_op = 1'b0; issue_fd = 5'd3;
      end else if (i >= 5 && i <= 20) begin
        issue_valid = 1'b1; issue_op = 1'b1; issue_fd = 5'd4;
      end
      step();
    end

    // fdiv fd=7 with an ID reader of f7, and the port taken on cycles 20..22.
    for (int i = 0; i < 28; i++) begin
      idle_inputs();
      if (i == 0) begin
        issue_valid = 1'b1; issue_fd = 5'd7;
      end else begin
        id_fs = 5'd7; id_use_fs = 1'b1;
      end
      if (i >= 20 && i <= 22) wb_port_free = 1'b0;
      step();
    end

    // Reset in the middle of an fdiv; no writeback may follow.
    idle_inputs();
    issue_valid = 1'b1; issue_fd = 5'd9;
    step();
    run_idle(9);
    do_reset(1);
    run_idle(15);

    // pipe_stall_in holds off the issue for three cycles.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      issue_valid = 1'b1; issue_op = 1'b1; issue_fd = 5'd0;
      pipe_stall_in = (i < 3);
      step();
    end
    run_idle(26);

    // Randomized traffic with a small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      idle_inputs();
      clrn          = ($urandom_range(0, 299) == 0);
      issue_valid   = !clrn && ($urandom_range(0, 3) != 0);
      issue_op      = 1'($urandom_range(0, 1));
      issue_fd      = 5'($urandom_range(0, 7));
      pipe_stall_in = ($urandom_range(0, 4) == 0);
      id_fs         = 5'($urandom_range(0, 7));
      id_ft         = 5'($urandom_range(0, 7));
      id_fd         = 5'($urandom_range(0, 7));
      id_use_fs     = ($urandom_range(0, 3) == 0);
      id_use_ft     = ($urandom_range(0, 3) == 0);
      id_wf         = ($urandom_range(0, 3) == 0);
      wb_port_free  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_divsqrt_sched.md
Name: fp_divsqrt_sched

Overview:
- Issue and writeback scheduler for the FPU's single shared iterative fdiv/fsqrt unit.
- Accepts a div/sqrt issue from the ID stage, pulses the unit's start, and counts down its latency.
- Arbitrates the result onto the FP register file's second write port against the pipelined e3 writer.
- Raises the pipeline stall for structural (unit busy) and RAW/WAW hazards on the in-flight destination register.

Parameters:
DIV_LAT, 20, fdiv latency in cycles from start pulse to result valid (1..32)
SQRT_LAT, 24, fsqrt latency in cycles (1..32)
CW, 5, count width

Ports:
clk  input  1  clock
clrn  input  1  reset; synchronous, active-high (1 clears)
issue_valid  input  1  ID holds an fdiv/fsqrt
issue_op  input  1  0=fdiv, 1=fsqrt
issue_fd  input  5  destination FPR of the issuing op
pipe_stall_in  input  1  other IU stall (lw/lwc1/...); blocks acceptance
id_fs  input  5  ID source register fs
id_ft  input  5  ID source register ft
id_use_fs  input  1  ID instruction reads fs
id_use_ft  input  1  ID instruction reads ft
id_wf  input  1  ID instruction writes an FPR
id_fd  input  5  ID destination FPR
wb_port_free  input  1  e3 stage not writing the FPR this cycle (~e3w)
start  output  1  one-cycle start pulse to the iterative unit
start_op  output  1  op qualifying start
busy  output  1  an op is in flight or its result is pending
count  output  CW  remaining cycles; 0 when idle
stall_ds  output  1  stall ID/IF
wb_we  output  1  write the div/sqrt result this cycle
wb_rn  output  5  destination register for wb_we
wb_op  output  1  op of the result being written

Behaviour:
- Reset (clrn=1 at a clk edge):
  - State goes to IDLE. All outputs are 0: count=0, busy=0, wb_we=0, start=0.
  - Latched fd/op are cleared.
  - An in-flight or pending result is discarded; no wb_we is issued afterwards.
- States: IDLE, RUN, WAIT_WB.
- "free_now" is true when:
  - state is IDLE; or
  - state is RUN with count==0 and wb_port_free; or
  - state is WAIT_WB with wb_port_free.
- Accept condition: accept = issue_valid & ~pipe_stall_in & free_now & ~haz.
- On accept:
  - start=1 and start_op=issue_op in that cycle (combinational).
  - Latch fd=issue_fd and op=issue_op.
  - Load count with DIV_LAT-1 or SQRT_LAT-1; next state is RUN.
- RUN:
  - count decrements by 1 each cycle while >0.
  - At count==0 with wb_port_free: wb_we=1, wb_rn=fd, wb_op=op. Next state is IDLE, or RUN if a new op is accepted in the same cycle (back-to-back allowed).
  - At count==0 with ~wb_port_free: go to WAIT_WB; count holds at 0.
- WAIT_WB:
  - Hold until wb_port_free, then wb_we=1 and go to IDLE (or RUN on a simultaneous accept).
  - The e3 writer always has priority over the div/sqrt result.
- busy = (state != IDLE).
- Hazard term haz: true when busy & ~wb_fire and any of the following match fd:
  - id_use_fs & id_fs==fd
  - id_use_ft & id_ft==fd
  - id_wf & id_fd==fd (WAW)
- The FPR write completes on the falling edge, so the hazard clears in the same cycle that wb_we=1.
- stall_ds = haz | (issue_valid & ~free_now). pipe_stall_in does not feed stall_ds; it only blocks accept.
- Register 0 is not special-cased; the FPR file has a real f0.
- Latency: the result is written SEL_LAT cycles after the start cycle when the port is free, where SEL_LAT is DIV_LAT or SQRT_LAT.

Optional Feature:
- FP_DIVSQRT_PERF_EN
- With the macro defined:
  - Adds output stall_cycles[31:0], which counts cycles with stall_ds=1.
  - The count saturates at 0xFFFFFFFF and is cleared by clrn.
  - Adds output wb_defer_cycles[15:0], which counts WAIT_WB cycles and saturates.
- Without the macro: neither port nor its counters exist; all other behaviour is identical.

Test Plan:
- Single fdiv, port free:
  - Stimulus: issue_valid=1, op=0, fd=3 at cycle 0, DIV_LAT=20.
  - Response: start=1 at cycle 0; count=19 at cycle 1; wb_we=1 and wb_rn=3 at cycle 20; busy=0 at cycle 21.
- Structural stall with back-to-back issue:
  - Stimulus: second fsqrt (fd=4) presented at cycle 5 of the fdiv.
  - Response: stall_ds=1 for cycles 5..19; at cycle 20 the cycle carries both wb_we(fd=3) and start(op=1); fsqrt writes at cycle 44.
- RAW hazard:
  - Stimulus: fdiv fd=7 in flight; ID add.s with id_fs=7, id_use_fs=1.
  - Response: stall_ds=1 until the wb_we cycle; stall_ds=0 in that cycle.
- Port conflict:
  - Stimulus: wb_port_free=0 for cycles 20..22.
  - Response: state WAIT_WB; wb_we=0 through cycle 22; wb_we=1 at cycle 23; an ID reader of fd stays stalled until cycle 23.
- Reset mid-operation:
  - Stimulus: clrn=1 at cycle 10 of an fdiv.
  - Response: next cycle busy=0, count=0, stall_ds=0; no wb_we at cycle 20.
- pipe_stall_in blocks issue:
  - Stimulus: issue_valid=1 with pipe_stall_in=1 for 3 cycles, then 0.
  - Response: no start during the 3 cycles; start on the 4th cycle; count loads LAT-1 then.
